local_port_arbiter: RTL and testbench
=====================================

# local_port_arbiter

Packet-level round-robin arbiter that shares a tile's single local NoC injection port (the switch's local-in stream) among up to N_REQ on-tile AXI-Stream requesters, such as accelerator output channels and the control path. A grant, once issued, is held until the granted requester's TLAST beat is accepted, so packets are never interleaved. A 2-entry output skid FIFO decouples switch backpressure from the requesters. A maximum-length guard stops a runaway requester from holding the port indefinitely.

## Interface
Parameters:
- BW, 32, stream data width in bits
- BWB, BW/8, TKEEP width
- N_REQ, 4, number of requesters (2..8)
- MAX_BEATS, 256, maximum beats per packet before a forced TLAST (2..65535)

Ports:
- clk_line  in  1  line clock; all logic is in this domain
- clk_line_rst_high  in  1  reset, synchronous, active-high
- req_TVALID  in  N_REQ  per-requester valid
- req_TDATA  in  N_REQ*BW  per-requester data; requester i occupies bits [i*BW +: BW]
- req_TKEEP  in  N_REQ*BWB  per-requester keep
- req_TLAST  in  N_REQ  per-requester last
- req_TREADY  out  N_REQ  per-requester ready; at most one bit is high
- enable_mask  in  N_REQ  requesters eligible for arbitration
- out_TVALID  out  1  to switch local-in valid
- out_TDATA  out  BW  to switch local-in data
- out_TKEEP  out  BWB  to switch local-in keep
- out_TLAST  out  1  to switch local-in last
- out_TREADY  in  1  from switch local-in ready
- grant_id  out  $clog2(N_REQ)  current or most recent grantee
- busy  out  1  high while in LOCKED
- pkt_done  out  1  one-cycle pulse when a packet's last beat is accepted from a requester
- err_len  out  1  sticky; set on forced TLAST, cleared only by reset

## Operation
- The FSM has two states, IDLE and LOCKED.
- IDLE:
  - cand = req_TVALID & enable_mask.
  - If cand is nonzero, select the first set bit scanning upward from (last_grant+1) mod N_REQ, with wrap-around.
  - Register the selection into grant_id and last_grant, clear beat_cnt, and go to LOCKED next cycle.
  - All req_TREADY are 0 in IDLE.
- LOCKED:
  - req_TREADY[grant_id] = (fifo_count < 2) or (fifo_count == 2 and out_TREADY high that cycle is not used). req_TREADY depends only on fifo_count, with no combinational path from out_TREADY.
  - An accepted beat (valid & ready) is pushed into the FIFO and increments beat_cnt.
  - The pushed TLAST is req_TLAST[g] OR (beat_cnt == MAX_BEATS-1).
  - If the TLAST came from the forced condition and not from req_TLAST, set err_len.
  - When the pushed TLAST is 1, pulse pkt_done and return to IDLE next cycle.
- After a forced TLAST, the requester's remaining beats are arbitrated as a new packet.
- enable_mask is sampled only in IDLE. Deasserting the mask bit of the current grantee mid-packet does not revoke the grant.
- FIFO:
  - 2 entries of {TDATA, TKEEP, TLAST}, first-word-fall-through.
  - out_TVALID = (fifo_count != 0); out_* shows the head entry.
  - Pop on out_TVALID & out_TREADY.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Push is never attempted when fifo_count == 2.
- The FIFO drains independently of the FSM, so arbitration for the next packet overlaps the draining of the previous one.
- beat_cnt width is $clog2(MAX_BEATS)+1. It never wraps, because it is cleared on every grant.

## Timing
- Reset values:
  - all outputs 0, including grant_id, busy, pkt_done and err_len
  - state IDLE, fifo_count 0
  - last_grant = N_REQ-1, so requester 0 has highest priority after reset
- Reset asserted mid-packet: the FIFO contents are discarded, the FSM goes to IDLE, and no pkt_done is issued. Requesters must restart their packets.
- Latency:
  - req_TVALID rising in IDLE at cycle t gives busy and req_TREADY at t+1.
  - The first beat is accepted at t+1 and appears on out_TVALID at t+2.
- Throughput: a packet of L beats occupies the requester side for L+1 cycles (1 arbitration cycle plus L beats) when out_TREADY is held high.
- Beats on the output are contiguous while out_TREADY stays high.
- out_TREADY held low: at most 2 beats are accepted, then req_TREADY drops. No beat is lost or duplicated.
- A requester dropping TVALID mid-packet only stalls transfer; the grant is held.
- AXI-Stream rules: out_TVALID never deasserts before it is accepted, and out_* are stable while out_TVALID=1 and out_TREADY=0.

## Test plan
- Single requester: req0 sends a 4-beat packet (data 0x10..0x13) with out_TREADY=1 → output beats appear at cycles t+2..t+5, TLAST on 0x13, pkt_done at t+4, busy low at t+5.
- Round-robin: all 4 requesters continuously valid with 2-beat packets → grant order 0,1,2,3,0,…; no interleaving; each packet takes 3 cycles.
- Mask: enable_mask=4'b1010 with all valid → grants alternate 1,3. Clearing bit 1 mid-packet → that packet still completes.
- Backpressure: out_TREADY=0 for 10 cycles during an 8-beat packet → exactly 2 beats buffered; after release, all 8 beats arrive in order, checked by a scoreboard.
- Length guard: MAX_BEATS=4, req2 sends 6 beats with TLAST only on the 6th → forced TLAST on beat 4 and err_len=1; beats 5-6 arrive as a new 2-beat packet after re-arbitration.
- Reset mid-packet: assert clk_line_rst_high for 1 cycle after beat 2 of 5 → all outputs 0 next cycle, FIFO empty, and the next grant goes to requester 0.

Source files
------------

// File: rtl/local_port_arbiter.sv
// Packet-level round-robin arbiter sharing one local NoC injection port
// among N_REQ AXI-Stream requesters. A grant is held until the grantee's
// last beat is accepted. A 2-entry first-word-fall-through skid FIFO sits
// in front of the switch. A beat-count guard forces TLAST on runaway packets.
module local_port_arbiter #(
    parameter int BW        = 32,
    parameter int BWB       = BW / 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BEATS = 256
) (
    input  logic                       clk_line,
    input  logic                       clk_line_rst_high,
    input  logic [N_REQ-1:0]           req_TVALID,
    input  logic [N_REQ*BW-1:0]        req_TDATA,
    input  logic [N_REQ*BWB-1:0]       req_TKEEP,
    input  logic [N_REQ-1:0]           req_TLAST,
    output logic [N_REQ-1:0]           req_TREADY,
    input  logic [N_REQ-1:0]           enable_mask,
    output logic                       out_TVALID,
    output logic [BW-1:0]              out_TDATA,
    output logic [BWB-1:0]             out_TKEEP,
    output logic                       out_TLAST,
    input  logic                       out_TREADY,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       pkt_done,
    output logic                       err_len
);

    localparam int          GW = $clog2(N_REQ);
    localparam int          CW = $clog2(MAX_BEATS) + 1;
    localparam int          EW = BW + BWB + 1;
    localparam int unsigned NR = N_REQ;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t         state;
    logic [GW-1:0]  last_grant;
    logic [CW-1:0]  beat_cnt;

    // Skid FIFO storage: entries are {TLAST, TKEEP, TDATA}
    logic [EW-1:0]  fifo_mem [2];
    logic [1:0]     fifo_count;
    logic           wr_ptr;
    logic           rd_ptr;
    logic [EW-1:0]  head;

    // Arbitration signals
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] cand_rot;
    logic             cand_any;
    int unsigned      start_idx;
    int unsigned      offset;
    logic [GW-1:0]    pick;

    // Datapath signals for the current grantee
    logic             g_valid;
    logic             g_last;
    logic [BW-1:0]    g_data;
    logic [BWB-1:0]   g_keep;
    logic             ready_int;
    logic             push;
    logic             pop;
    logic             len_hit;
    logic             push_last;

    // Round-robin pick: rotate candidates so the scan starts just past the
    // last grantee, take the lowest set bit, then rotate the index back.
    always_comb begin
        cand      = req_TVALID & enable_mask;
        cand_any  = |cand;
        start_idx = (32'(last_grant) + 32'd1) % NR;
        cand_rot  = N_REQ'({cand, cand} >> start_idx);
        offset    = 0;
        for (int unsigned i = NR; i > 0; i--) begin
            if (cand_rot[i-1]) begin
                offset = i - 1;
            end
        end
        pick = GW'((start_idx + offset) % NR);
    end

    // Grantee beat path, ready generation and forced-TLAST detection
    always_comb begin
        g_valid   = req_TVALID[grant_id];
        g_last    = req_TLAST[grant_id];
        g_data    = req_TDATA[grant_id*BW +: BW];
        g_keep    = req_TKEEP[grant_id*BWB +: BWB];
        // Ready depends only on registered occupancy, never on out_TREADY.
        ready_int = (state == LOCKED) && (fifo_count < 2'd2) && !clk_line_rst_high;
        req_TREADY = '0;
        if (ready_int) begin
            req_TREADY[grant_id] = 1'b1;
        end
        push      = ready_int && g_valid;
        len_hit   = (beat_cnt == CW'(MAX_BEATS - 1));
        push_last = g_last || len_hit;
        // Pulses in the same cycle the last beat is accepted.
        pkt_done  = push && push_last;
    end

    // FIFO output view and pop condition
    always_comb begin
        head       = fifo_mem[rd_ptr];
        out_TVALID = (fifo_count != 2'd0);
        out_TDATA  = out_TVALID ? head[BW-1:0]     : '0;
        out_TKEEP  = out_TVALID ? head[BW +: BWB]  : '0;
        out_TLAST  = out_TVALID ? head[EW-1]       : 1'b0;
        pop        = out_TVALID && out_TREADY;
        busy       = (state == LOCKED);
    end

    // Arbitration FSM: grant on IDLE, hold until the pushed beat carries TLAST
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_REQ - 1);
            beat_cnt   <= '0;
            err_len    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                        state      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (push) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (push_last) begin
                            state <= IDLE;
                        end
                        if (len_hit && !g_last) begin
                            err_len <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid FIFO, drains independently of the arbitration FSM
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            fifo_count <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {push_last, g_keep, g_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_local_port_arbiter.sv
// Bench for local_port_arbiter: directed phases with random data/backpressure,
// checked every cycle against a packet-level reference model.
module tb_local_port_arbiter;

    localparam int BW   = 32;
    localparam int BWB  = 4;
    localparam int N    = 4;
    localparam int MAXB = 8;

    typedef logic [BW+BWB:0] beat_t;   // {last, keep, data}

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_TVALID;
    logic [N*BW-1:0]    req_TDATA;
    logic [N*BWB-1:0]   req_TKEEP;
    logic [N-1:0]       req_TLAST;
    logic [N-1:0]       req_TREADY;
    logic [N-1:0]       enable_mask;
    logic               out_TVALID;
    logic [BW-1:0]      out_TDATA;
    logic [BWB-1:0]     out_TKEEP;
    logic               out_TLAST;
    logic               out_TREADY;
    logic [1:0]         grant_id;
    logic               busy;
    logic               pkt_done;
    logic               err_len;

    local_port_arbiter #(
        .BW(BW), .BWB(BWB), .N_REQ(N), .MAX_BEATS(MAXB)
    ) dut (
        .clk_line(clk), .clk_line_rst_high(rst),
        .req_TVALID(req_TVALID), .req_TDATA(req_TDATA), .req_TKEEP(req_TKEEP),
        .req_TLAST(req_TLAST), .req_TREADY(req_TREADY), .enable_mask(enable_mask),
        .out_TVALID(out_TVALID), .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP),
        .out_TLAST(out_TLAST), .out_TREADY(out_TREADY), .grant_id(grant_id),
        .busy(busy), .pkt_done(pkt_done), .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester packet queues and output scoreboard
    beat_t rq [N][$];
    beat_t sb [$];

    int checks;
    int errors;

    logic [N-1:0] vld;
    logic         oready;
    bit           gaps;

    // Packet-level reference model
    bit    m_locked, m_err, m_fresh;
    int    m_owner, m_last, m_cnt;
    bit    acc, pop, acc_last, acc_forced, arb;
    int    arb_pick;
    beat_t acc_beat;

    // Observation logs
    int    glog [$];
    int    plen [$];
    bit    log_en;
    logic  prev_busy;
    int    obs_acc;
    int    pcur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input int base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b[BW-1:0]      = (base >= 0) ? BW'(base + k) : BW'($urandom);
            b[BW +: BWB]   = (base >= 0) ? '1 : BWB'($urandom);
            b[BW+BWB]      = (k == len - 1);
            rq[r].push_back(b);
        end
    endtask

    task automatic drive();
        logic [N*BW-1:0]  td;
        logic [N*BWB-1:0] tk;
        logic [N-1:0]     tl;
        beat_t            h;
        td = '0; tk = '0; tl = '0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                vld[i] = 1'b1;
                h = rq[i][0];
                td[i*BW +: BW]   = h[BW-1:0];
                tk[i*BWB +: BWB] = h[BW +: BWB];
                tl[i]            = h[BW+BWB];
            end else begin
                vld[i] = 1'b0;
            end
        end
        req_TVALID = vld;
        req_TDATA  = td;
        req_TKEEP  = tk;
        req_TLAST  = tl;
        out_TREADY = oready;
    endtask

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_fresh = 1;
        m_owner = 0; m_last = N - 1; m_cnt = 0;
        acc = 0; pop = 0; arb = 0;
        prev_busy = 1'b0;
        sb.delete();
    endtask

    task automatic evaluate();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] cand;
        exp_rdy = '0;
        if (m_locked && sb.size() < 2) exp_rdy[m_owner] = 1'b1;
        chk("req_tready", 64'(req_TREADY), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_locked));
        if (m_locked) chk("grant_id", 64'(grant_id), 64'(m_owner));
        if (m_fresh) begin
            chk("grant_id_rst", 64'(grant_id), 64'd0);
            chk("out_data_rst", 64'({out_TLAST, out_TKEEP, out_TDATA}), 64'd0);
        end
        chk("out_tvalid", 64'(out_TVALID), 64'(sb.size() != 0));
        if (sb.size() != 0) chk("out_beat", 64'({out_TLAST, out_TKEEP, out_TDATA}), 64'(sb[0]));
        chk("err_len", 64'(err_len), 64'(m_err));

        acc = m_locked && vld[m_owner] && (sb.size() < 2);
        acc_last = 0; acc_forced = 0;
        if (acc) begin
            acc_beat   = rq[m_owner][0];
            acc_last   = acc_beat[BW+BWB] || (m_cnt == MAXB - 1);
            acc_forced = acc_last && !acc_beat[BW+BWB];
        end
        chk("pkt_done", 64'(pkt_done), 64'(acc && acc_last));
        pop = (sb.size() != 0) && oready;

        arb = 0;
        if (!m_locked) begin
            cand = vld & enable_mask;
            for (int k = 1; k <= N; k++) begin
                if (!arb && cand[(m_last + k) % N]) begin
                    arb = 1;
                    arb_pick = (m_last + k) % N;
                end
            end
        end

        if (log_en && busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;
        if ((req_TREADY & req_TVALID) != '0) obs_acc++;
        if (out_TVALID && out_TREADY) begin
            pcur++;
            if (out_TLAST) begin
                plen.push_back(pcur);
                pcur = 0;
            end
        end
    endtask

    task automatic model_update();
        if (acc) begin
            sb.push_back({acc_last, acc_beat[BW+BWB-1:0]});
            void'(rq[m_owner].pop_front());
            m_cnt++;
            if (acc_last) begin
                m_locked = 0;
                if (acc_forced) m_err = 1;
            end
        end
        if (pop) void'(sb.pop_front());
        if (arb) begin
            m_locked = 1; m_owner = arb_pick; m_last = arb_pick;
            m_cnt = 0; m_fresh = 0;
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        if (!rst) evaluate();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_update();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1;
        return (sb.size() != 0) || m_locked;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            errors++;
            $error("FAIL drain_timeout observed=%0d cycles expected=<%0d", n, budget);
        end
    endtask

    int exp_m [8];
    int n;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; oready = 1'b1; enable_mask = '1; gaps = 0;
        log_en = 0; prev_busy = 1'b0; obs_acc = 0; pcur = 0; vld = '0;
        model_reset();
        do_reset(2);
        tick();

        // Single requester, 4-beat packet 0x10..0x13
        plen.delete();
        add_pkt(0, 4, 'h10);
        drain(50);
        chk("single_npkts", 64'(plen.size()), 64'd1);
        if (plen.size() > 0) chk("single_len", 64'(plen[0]), 64'd4);

        // Round-robin: requester 0 was served last, so order starts at 1
        glog.delete(); log_en = 1;
        for (int r = 0; r < N; r++) for (int p = 0; p < 3; p++) add_pkt(r, 2, -1);
        drain(100);
        log_en = 0;
        chk("rr_ngrants", 64'(glog.size()), 64'd12);
        for (int k = 0; k < glog.size() && k < 12; k++)
            chk("rr_order", 64'(glog[k]), 64'((1 + k) % N));

        // Mask 1010, then drop bit 1 while requester 1 holds the grant
        enable_mask = 4'b1010;
        glog.delete(); log_en = 1;
        for (int r = 0; r < N; r++) for (int p = 0; p < 2; p++) add_pkt(r, 3, -1);
        repeat (10) tick();
        enable_mask = 4'b1000;
        repeat (8) tick();
        enable_mask = '1;
        drain(100);
        log_en = 0;
        exp_m = '{1, 3, 1, 3, 0, 2, 0, 2};
        chk("mask_ngrants", 64'(glog.size()), 64'd8);
        for (int k = 0; k < glog.size() && k < 8; k++)
            chk("mask_order", 64'(glog[k]), 64'(exp_m[k]));

        // Backpressure: output stalled from the grant onward for 10 beat cycles
        plen.delete(); obs_acc = 0; oready = 1'b0;
        add_pkt(1, 8, -1);
        repeat (11) tick();
        chk("stall_accepts", 64'(obs_acc), 64'd2);
        oready = 1'b1;
        drain(100);
        chk("bp_npkts", 64'(plen.size()), 64'd1);
        if (plen.size() > 0) chk("bp_len", 64'(plen[0]), 64'd8);
        chk("bp_no_err", 64'(err_len), 64'd0);

        // Length guard: 10 beats with MAX_BEATS=8 splits into 8 + 2
        plen.delete();
        add_pkt(2, 10, 'h200);
        drain(100);
        chk("guard_npkts", 64'(plen.size()), 64'd2);
        if (plen.size() > 1) begin
            chk("guard_len0", 64'(plen[0]), 64'd8);
            chk("guard_len1", 64'(plen[1]), 64'd2);
        end
        chk("guard_err", 64'(err_len), 64'd1);

        // Random traffic, gaps, backpressure and mask changes
        gaps = 1;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) add_pkt(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 12)), -1);
            if (t % 50 == 0) enable_mask = 4'($urandom_range(1, 15));
            oready = ($urandom_range(0, 3) != 0);
            tick();
        end
        enable_mask = '1; gaps = 0; oready = 1'b1;
        drain(3000);

        // Reset after beat 2 of a 5-beat packet
        add_pkt(3, 5, 'h300);
        n = 0;
        while (!(m_locked && m_cnt == 2) && n < 20) begin
            tick();
            n++;
        end
        chk("pre_reset_locked", 64'(busy), 64'd1);
        do_reset(1);
        tick();
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_err", 64'(err_len), 64'd0);
        glog.delete(); log_en = 1;
        for (int r = N - 1; r >= 0; r--) add_pkt(r, 2, -1);
        drain(100);
        log_en = 0;
        chk("post_reset_ngrants", 64'(glog.size()), 64'd4);
        if (glog.size() > 0) chk("post_reset_first", 64'(glog[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
